// File: rtl/rib_wait_slave.sv
// rib_wait_slave: word-addressed RAM responder for the RIB interconnect with
// LATENCY wait states, abort on req withdrawal and restart on a changed request.
module rib_wait_slave #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        we_i,
    input  logic        req_i,
    output logic [31:0] data_o,
    output logic        ready_o
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("rib_wait_slave: LATENCY must be within 0..15");
    end

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
    logic        we_q, we_d, ready_q, ready_d;
    logic        commit, wr;
    logic [ADDR_W-1:0] idx;
    logic [31:0] mem [1 << ADDR_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: if (req_i) begin
                addr_d  = addr_i;
                data_d  = data_i;
                we_d    = we_i;
                cnt_d   = LAT;
                state_d = (LAT == 4'd0) ? RESP : WAIT;
                commit  = (LAT == 4'd0);
            end
            WAIT: if (!req_i) begin
                state_d = IDLE;
            end else if ({addr_i, data_i, we_i} != {addr_q, data_q, we_q}) begin
                addr_d = addr_i;
                data_d = data_i;
                we_d   = we_i;
                cnt_d  = LAT;
            end else if (cnt_q == 4'd1) begin
                state_d = RESP;
                commit  = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
        // commit always uses the freshly latched request, which covers the zero-latency path
        idx     = addr_d[2 +: ADDR_W];
        wr      = commit && we_d;
        ready_d = commit;
        rdata_d = (commit && !we_d) ? mem[idx] : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[idx] <= data_d;
    end

    assign data_o  = rdata_q;
    assign ready_o = ready_q;
endmodule

// File: tb/tb_rib_wait_slave.sv
// tb_rib_wait_slave: directed checks of a LATENCY=2 and a LATENCY=0 rib_wait_slave.
module tb_rib_wait_slave;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        we = 1'b0, req = 1'b0, ready;
    logic [31:0] addr0 = '0, wdata0 = '0, rdata0;
    logic        we0 = 1'b0, req0 = 1'b0, ready0;
    int          ntests = 0, nfail = 0;

    always #5 clk = ~clk;

    rib_wait_slave #(.ADDR_W(12), .LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .addr_i(addr), .data_i(wdata), .we_i(we),
        .req_i(req), .data_o(rdata), .ready_o(ready)
    );

    rib_wait_slave #(.ADDR_W(12), .LATENCY(0)) u_l0 (
        .clk(clk), .rst_n(rst_n), .addr_i(addr0), .data_i(wdata0), .we_i(we0),
        .req_i(req0), .data_o(rdata0), .ready_o(ready0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One LATENCY=2 transaction starting just after a rising edge; lat is the ready cycle or -1.
    task automatic xact(input logic [31:0] a, input logic [31:0] d, input logic w,
                        output logic [31:0] rd, output int lat);
        addr = a; wdata = d; we = w; req = 1'b1; lat = -1; rd = '0;
        for (int c = 0; c < 20 && lat < 0; c++) begin
            @(negedge clk);
            if (ready) begin
                lat = c;
                rd  = rdata;
            end else if (rdata !== 32'd0) begin
                chk("quiet_data", rdata, 32'd0);
            end
            @(posedge clk); #1;
        end
        req = 1'b0;
        @(negedge clk);
        chk("ready_clear", {31'd0, ready}, 32'd0);
        chk("data_clear", rdata, 32'd0);
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    int          lat;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_data", rdata, 32'd0);
        chk("rst_ready0", {31'd0, ready0}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        xact(32'h6000_0010, 32'h0, 1'b0, rd, lat);
        chk("read_lat", 32'(lat), 32'd3);

        xact(32'h6000_0008, 32'hDEAD_BEEF, 1'b1, rd, lat);
        chk("write_lat", 32'(lat), 32'd3);
        chk("write_data_o", rd, 32'd0);
        xact(32'h6000_0008, 32'h0, 1'b0, rd, lat);
        chk("raw_lat", 32'(lat), 32'd3);
        chk("raw_data", rd, 32'hDEAD_BEEF);

        // abort: req dropped in the first WAIT cycle
        xact(32'h6000_0010, 32'hDEAD_BEEF, 1'b1, rd, lat);
        addr = 32'h6000_0010; wdata = 32'h1234_5678; we = 1'b1; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        for (int c = 1; c < 6; c++) begin
            @(negedge clk);
            chk("abort_ready", {31'd0, ready}, 32'd0);
            @(posedge clk); #1;
        end
        xact(32'h6000_0010, 32'h0, 1'b0, rd, lat);
        chk("abort_keep", rd, 32'hDEAD_BEEF);

        // restart: address changes in WAIT with req held
        xact(32'h6000_0000, 32'h0BAD_0000, 1'b1, rd, lat);
        xact(32'h6000_0004, 32'h1111_1111, 1'b1, rd, lat);
        addr = 32'h6000_0000; we = 1'b0; req = 1'b1; lat = -1;
        @(posedge clk); #1;
        addr = 32'h6000_0004;
        for (int c = 1; c < 20 && lat < 0; c++) begin
            @(negedge clk);
            if (ready) begin lat = c; rd = rdata; end
            @(posedge clk); #1;
        end
        req = 1'b0;
        chk("restart_lat", 32'(lat), 32'd4);
        chk("restart_data", rd, 32'h1111_1111);
        @(posedge clk); #1;

        // reset during RESP clears outputs asynchronously
        addr = 32'h6000_0008; we = 1'b0; req = 1'b1; lat = -1;
        for (int c = 0; c < 20 && lat < 0; c++) begin
            @(negedge clk);
            if (ready) lat = c;
            else begin @(posedge clk); #1; end
        end
        chk("resp_lat", 32'(lat), 32'd3);
        chk("resp_data", rdata, 32'hDEAD_BEEF);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ready", {31'd0, ready}, 32'd0);
        chk("async_data", rdata, 32'd0);
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // reset during WAIT of a write drops the write
        xact(32'h6000_001C, 32'h5555_AAAA, 1'b1, rd, lat);
        addr = 32'h6000_001C; wdata = 32'hA5A5_A5A5; we = 1'b1; req = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        chk("midrst_data", rdata, 32'd0);
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        xact(32'h6000_001C, 32'h0, 1'b0, rd, lat);
        chk("midrst_keep", rd, 32'h5555_AAAA);
        chk("midrst_lat", 32'(lat), 32'd3);

        // LATENCY=0: write then back-to-back reads with req held throughout
        addr0 = 32'h6000_000C; wdata0 = 32'hCAFE_F00D; we0 = 1'b1; req0 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 2) we0 = 1'b0;
            @(negedge clk);
            chk($sformatf("l0_ready_c%0d", c), {31'd0, ready0}, {31'd0, c[0]});
            chk($sformatf("l0_data_c%0d", c), rdata0,
                (c[0] && c > 1) ? 32'hCAFE_F00D : 32'd0);
            @(posedge clk); #1;
        end
        req0 = 1'b0;
        @(negedge clk);
        chk("l0_idle", {31'd0, ready0}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
